clint_ctrl: RTL and testbench

Core-local interrupt/trap controller that sequences machine-mode CSR updates on trap entry (ecall, ebreak, external/timer interrupt) and trap return (mret).
- Sits between id/ex and the CSR register file.
- Stalls the pipeline while sequencing.
- Writes mepc/mstatus/mcause through the CSR file's secondary (clint) write port.
- Issues a redirect to mtvec or mepc.

---
 rtl/clint_ctrl_pkg.sv | 55 +++++
 rtl/clint_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_clint_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clint_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// clint_ctrl_pkg
// Shared definitions for the core-local interrupt/trap controller:
//   - machine-mode CSR addresses touched by the trap sequencer
//   - SYSTEM instruction encodings decoded in id
//   - default mcause values
//   - sequencer state encoding
//   - mstatus rewrite helpers for trap entry and mret
// ----------------------------------------------------------------------------
package clint_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] DEF_CAUSE_ECALL  = 32'h0000_000B;
  localparam logic [31:0] DEF_CAUSE_EBREAK = 32'h0000_0003;
  localparam logic [31:0] DEF_CAUSE_INT    = 32'h8000_0007;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_W_MEPC       = 3'd1,
    S_W_MSTATUS    = 3'd2,
    S_W_MCAUSE     = 3'd3,
    S_MRET_MSTATUS = 3'd4,
    S_ASSERT       = 3'd5
  } state_e;

  // Trap entry: remember the interrupt enable in MPIE, then disable interrupts.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] mstatus);
    logic [31:0] r;
    r               = mstatus;
    r[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // mret: restore MIE from MPIE, and MPIE is set back to 1.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] mstatus);
    logic [31:0] r;
    r               = mstatus;
    r[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_ctrl.sv
// ----------------------------------------------------------------------------
// clint_ctrl
// Sequences machine-mode CSR updates on trap entry (ecall, ebreak, interrupt)
// and trap return (mret), stalling the pipeline while it runs and finishing
// with a one-cycle redirect to mtvec or mepc.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   inst_i             instruction in id
//   inst_addr_i        PC of the instruction in id
//   int_flag_i         pending external interrupt lines (nonzero = request)
//   jump_flag_i        ex is redirecting this cycle
//   jump_addr_i        ex redirect target
//   ex_csr_we_i        ex is writing the CSR file this cycle (has priority)
//   csr_mtvec_i        current mtvec
//   csr_mepc_i         current mepc
//   csr_mstatus_i      current mstatus
//   global_int_en_i    mstatus.MIE
//   hold_o             pipeline stall request
//   we_o               CSR write enable on the clint write port
//   waddr_o            CSR write address (12-bit, zero-extended)
//   wdata_o            CSR write data
//   int_assert_o       one-cycle redirect pulse
//   int_addr_o         redirect target
// ----------------------------------------------------------------------------
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter logic [31:0] CAUSE_ECALL  = DEF_CAUSE_ECALL,
  parameter logic [31:0] CAUSE_EBREAK = DEF_CAUSE_EBREAK,
  parameter logic [31:0] CAUSE_INT    = DEF_CAUSE_INT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [7:0]  int_flag_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_csr_we_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic        global_int_en_i,
  output logic        hold_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] wdata_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] target_q, target_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        int_assert_q, int_assert_d;
  logic [31:0] int_addr_q, int_addr_d;
  logic        accept;
  logic        int_ok;

  assign int_ok = (int_flag_i != 8'd0) && global_int_en_i;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    target_d = target_q;
    accept   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Priority: ecall > ebreak > mret > interrupt.
        if (inst_i == INST_ECALL) begin
          accept   = 1'b1;
          state_d  = S_W_MEPC;
          epc_d    = inst_addr_i;
          cause_d  = CAUSE_ECALL;
          target_d = csr_mtvec_i;
        end else if (inst_i == INST_EBREAK) begin
          accept   = 1'b1;
          state_d  = S_W_MEPC;
          epc_d    = inst_addr_i;
          cause_d  = CAUSE_EBREAK;
          target_d = csr_mtvec_i;
        end else if (inst_i == INST_MRET) begin
          accept   = 1'b1;
          state_d  = S_MRET_MSTATUS;
          target_d = csr_mepc_i;
        end else if (int_ok) begin
          // A taken branch in ex means id holds a squashed instruction; the
          // interrupt must resume at the branch target instead.
          accept   = 1'b1;
          state_d  = S_W_MEPC;
          epc_d    = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d  = CAUSE_INT;
          target_d = csr_mtvec_i;
        end
      end
      // The CSR file lets ex win a same-cycle write, so a write state only
      // advances once its write goes out without a collision.
      S_W_MEPC:       if (!ex_csr_we_i) state_d = S_W_MSTATUS;
      S_W_MSTATUS:    if (!ex_csr_we_i) state_d = S_W_MCAUSE;
      S_W_MCAUSE:     if (!ex_csr_we_i) state_d = S_ASSERT;
      S_MRET_MSTATUS: if (!ex_csr_we_i) state_d = S_ASSERT;
      S_ASSERT:       state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase

    // Outputs are registered: compute what the next state must present.
    we_d         = 1'b0;
    waddr_d      = 12'h000;
    wdata_d      = 32'h0;
    int_assert_d = 1'b0;
    int_addr_d   = 32'h0;
    case (state_d)
      S_W_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        wdata_d = epc_d;
      end
      S_W_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        wdata_d = mstatus_on_trap(csr_mstatus_i);
      end
      S_W_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        wdata_d = cause_d;
      end
      S_MRET_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        wdata_d = mstatus_on_mret(csr_mstatus_i);
      end
      S_ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = target_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      epc_q        <= 32'h0;
      cause_q      <= 32'h0;
      target_q     <= 32'h0;
      we_q         <= 1'b0;
      waddr_q      <= 12'h000;
      wdata_q      <= 32'h0;
      int_assert_q <= 1'b0;
      int_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      target_q     <= target_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  // Stall in the acceptance cycle already, so id does not advance past the
  // trapping instruction; released while reset is held.
  assign hold_o = rst_n && ((state_q != S_IDLE) || accept);

  // A write that collides with ex would be lost; suppress it in that cycle.
  assign we_o         = we_q && !ex_csr_we_i;
  assign waddr_o      = {20'h0, waddr_q};
  assign wdata_o      = wdata_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;

endmodule

// File: tb/tb_clint_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clint_ctrl
// Directed bench for clint_ctrl. A behavioural model turns every accepted
// request into a list of CSR actions (writes, then a redirect) and plays it
// out one action per cycle, re-trying a write while ex holds the CSR port.
// A compare process checks the DUT against that model on every falling edge;
// the directed sequence adds hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_clint_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic [7:0]  int_flag_i;
  logic        jump_flag_i, ex_csr_we_i, global_int_en_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        hold_o, we_o, int_assert_o;
  logic [31:0] waddr_o, wdata_o, int_addr_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  clint_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_i         (inst_i),
    .inst_addr_i    (inst_addr_i),
    .int_flag_i     (int_flag_i),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .ex_csr_we_i    (ex_csr_we_i),
    .csr_mtvec_i    (csr_mtvec_i),
    .csr_mepc_i     (csr_mepc_i),
    .csr_mstatus_i  (csr_mstatus_i),
    .global_int_en_i(global_int_en_i),
    .hold_o         (hold_o),
    .we_o           (we_o),
    .waddr_o        (waddr_o),
    .wdata_o        (wdata_o),
    .int_assert_o   (int_assert_o),
    .int_addr_o     (int_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          is_write;
    logic [11:0] addr;
    logic [31:0] data;   // write data, or redirect target
  } act_t;

  act_t q[$];
  bit   rst_prev = 1'b0;

  function automatic act_t wr(input logic [11:0] a, input logic [31:0] d);
    act_t x;
    x.is_write = 1'b1; x.addr = a; x.data = d;
    return x;
  endfunction

  function automatic act_t redir(input logic [31:0] t);
    act_t x;
    x.is_write = 1'b0; x.addr = 12'h0; x.data = t;
    return x;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      logic        e_hold, e_we, e_ia, stall, acc;
      logic [31:0] e_waddr, e_wdata, e_iaddr, epc, cause, m;
      e_hold = 0; e_we = 0; e_ia = 0; stall = 0; acc = 0;
      e_waddr = 0; e_wdata = 0; e_iaddr = 0; epc = 0; cause = 0;
      m = csr_mstatus_i;
      if (q.size() > 0) begin
        e_hold = rst_n;
        if (q[0].is_write) begin
          if (ex_csr_we_i) stall = 1;
          else begin
            e_we = 1; e_waddr = {20'h0, q[0].addr}; e_wdata = q[0].data;
          end
        end else begin
          e_ia = 1; e_iaddr = q[0].data;
        end
      end else if (rst_n) begin
        if (inst_i == ECALL)       begin acc = 1; epc = inst_addr_i; cause = 32'h0000_000B; end
        else if (inst_i == EBREAK) begin acc = 1; epc = inst_addr_i; cause = 32'h0000_0003; end
        else if (inst_i == MRET)   acc = 1;
        else if (int_flag_i != 0 && global_int_en_i) begin
          acc = 1; epc = jump_flag_i ? jump_addr_i : inst_addr_i; cause = 32'h8000_0007;
        end
        e_hold = acc;
      end

      check("m_hold", {31'b0, hold_o}, {31'b0, e_hold});
      check("m_we", {31'b0, we_o}, {31'b0, e_we});
      check("m_int_assert", {31'b0, int_assert_o}, {31'b0, e_ia});
      if (e_we) begin
        check("m_waddr", waddr_o, e_waddr);
        check("m_wdata", wdata_o, e_wdata);
      end
      if (e_ia) check("m_int_addr", int_addr_o, e_iaddr);
      if (rst_prev) begin
        check("m_rst_waddr", waddr_o, 32'h0);
        check("m_rst_wdata", wdata_o, 32'h0);
        check("m_rst_int_addr", int_addr_o, 32'h0);
      end

      // Effects of the coming clock edge.
      rst_prev = !rst_n;
      if (!rst_n) q.delete();
      else if (q.size() > 0) begin
        if (!stall) void'(q.pop_front());
      end else if (acc) begin
        if (inst_i == MRET) begin
          // MIE <- MPIE, MPIE <- 1
          q.push_back(wr(12'h300, (m & ~32'h8) | ((m >> 4) & 32'h8) | 32'h80));
          q.push_back(redir(csr_mepc_i));
        end else begin
          // MPIE <- MIE, MIE <- 0
          q.push_back(wr(12'h341, epc));
          q.push_back(wr(12'h300, (m & ~32'h88) | ((m & 32'h8) << 4)));
          q.push_back(wr(12'h342, cause));
          q.push_back(redir(csr_mtvec_i));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample at the falling edge, compare literals, then move to the next cycle.
  task automatic expect_cyc(input string name, input logic hold, input logic we,
                            input logic [31:0] waddr, input logic [31:0] wdata,
                            input logic ia, input logic [31:0] iaddr);
    @(negedge clk);
    check({name, "_hold"}, {31'b0, hold_o}, {31'b0, hold});
    check({name, "_we"}, {31'b0, we_o}, {31'b0, we});
    check({name, "_int_assert"}, {31'b0, int_assert_o}, {31'b0, ia});
    if (we) begin
      check({name, "_waddr"}, waddr_o, waddr);
      check({name, "_wdata"}, wdata_o, wdata);
    end
    if (ia) check({name, "_int_addr"}, int_addr_o, iaddr);
    next_cycle();
  endtask

  initial begin
    rst_n = 0; inst_i = NOP; inst_addr_i = 0; int_flag_i = 0;
    jump_flag_i = 0; jump_addr_i = 0; ex_csr_we_i = 0; global_int_en_i = 0;
    csr_mtvec_i = 32'h200; csr_mepc_i = 0; csr_mstatus_i = 32'h08;
    next_cycle();
    started = 1;
    expect_cyc("reset0", 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    expect_cyc("idle0", 0, 0, 0, 0, 0, 0);

    // ecall at 0x100
    inst_i = ECALL; inst_addr_i = 32'h100;
    expect_cyc("ecall_acc", 1, 0, 0, 0, 0, 0);
    inst_i = NOP;
    expect_cyc("ecall_mepc",    1, 1, 32'h341, 32'h100, 0, 0);
    expect_cyc("ecall_mstatus", 1, 1, 32'h300, 32'h80,  0, 0);
    expect_cyc("ecall_mcause",  1, 1, 32'h342, 32'hB,   0, 0);
    expect_cyc("ecall_assert",  1, 0, 0, 0, 1, 32'h200);
    expect_cyc("ecall_done",    0, 0, 0, 0, 0, 0);

    // mret
    csr_mepc_i = 32'h104; csr_mstatus_i = 32'h80; inst_i = MRET;
    expect_cyc("mret_acc", 1, 0, 0, 0, 0, 0);
    inst_i = NOP;
    expect_cyc("mret_mstatus", 1, 1, 32'h300, 32'h88, 0, 0);
    expect_cyc("mret_assert",  1, 0, 0, 0, 1, 32'h104);
    expect_cyc("mret_done",    0, 0, 0, 0, 0, 0);

    // interrupt gated by MIE
    csr_mstatus_i = 32'h08; int_flag_i = 8'h01; global_int_en_i = 0;
    inst_addr_i = 32'h140;
    expect_cyc("int_masked0", 0, 0, 0, 0, 0, 0);
    expect_cyc("int_masked1", 0, 0, 0, 0, 0, 0);
    global_int_en_i = 1; jump_flag_i = 1; jump_addr_i = 32'h300;
    expect_cyc("int_acc", 1, 0, 0, 0, 0, 0);
    int_flag_i = 0; jump_flag_i = 0; global_int_en_i = 0;
    expect_cyc("int_mepc",    1, 1, 32'h341, 32'h300, 0, 0);
    expect_cyc("int_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    expect_cyc("int_mcause",  1, 1, 32'h342, 32'h8000_0007, 0, 0);
    expect_cyc("int_assert",  1, 0, 0, 0, 1, 32'h200);
    expect_cyc("int_done",    0, 0, 0, 0, 0, 0);

    // ebreak
    inst_i = EBREAK; inst_addr_i = 32'h150;
    expect_cyc("ebreak_acc", 1, 0, 0, 0, 0, 0);
    inst_i = NOP;
    expect_cyc("ebreak_mepc",    1, 1, 32'h341, 32'h150, 0, 0);
    expect_cyc("ebreak_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    expect_cyc("ebreak_mcause",  1, 1, 32'h342, 32'h3, 0, 0);
    expect_cyc("ebreak_assert",  1, 0, 0, 0, 1, 32'h200);

    // collision during W_MSTATUS
    inst_i = ECALL; inst_addr_i = 32'h180;
    expect_cyc("col_acc", 1, 0, 0, 0, 0, 0);
    inst_i = NOP;
    expect_cyc("col_mepc", 1, 1, 32'h341, 32'h180, 0, 0);
    ex_csr_we_i = 1;
    expect_cyc("col_stall0", 1, 0, 0, 0, 0, 0);
    expect_cyc("col_stall1", 1, 0, 0, 0, 0, 0);
    ex_csr_we_i = 0;
    expect_cyc("col_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    expect_cyc("col_mcause",  1, 1, 32'h342, 32'hB, 0, 0);
    expect_cyc("col_assert",  1, 0, 0, 0, 1, 32'h200);
    expect_cyc("col_done",    0, 0, 0, 0, 0, 0);

    // ecall and interrupt together: ecall wins, one sequence only
    inst_i = ECALL; inst_addr_i = 32'h1C0; int_flag_i = 8'h01; global_int_en_i = 1;
    expect_cyc("both_acc", 1, 0, 0, 0, 0, 0);
    inst_i = NOP; global_int_en_i = 0;   // MIE is now being cleared
    expect_cyc("both_mepc",    1, 1, 32'h341, 32'h1C0, 0, 0);
    expect_cyc("both_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    expect_cyc("both_mcause",  1, 1, 32'h342, 32'hB, 0, 0);
    expect_cyc("both_assert",  1, 0, 0, 0, 1, 32'h200);
    expect_cyc("both_done0",   0, 0, 0, 0, 0, 0);
    expect_cyc("both_done1",   0, 0, 0, 0, 0, 0);
    int_flag_i = 0;

    // reset during W_MCAUSE
    inst_i = ECALL; inst_addr_i = 32'h200;
    expect_cyc("rst_acc", 1, 0, 0, 0, 0, 0);
    inst_i = NOP;
    expect_cyc("rst_mepc",    1, 1, 32'h341, 32'h200, 0, 0);
    expect_cyc("rst_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    rst_n = 0;
    @(negedge clk);
    check("rst_hold_low", {31'b0, hold_o}, 32'h0);
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    check("rst_after_we", {31'b0, we_o}, 32'h0);
    check("rst_after_waddr", waddr_o, 32'h0);
    check("rst_after_wdata", wdata_o, 32'h0);
    check("rst_after_int_assert", {31'b0, int_assert_o}, 32'h0);
    check("rst_after_int_addr", int_addr_o, 32'h0);
    check("rst_after_hold", {31'b0, hold_o}, 32'h0);
    next_cycle();
    expect_cyc("rst_no_assert0", 0, 0, 0, 0, 0, 0);
    expect_cyc("rst_no_assert1", 0, 0, 0, 0, 0, 0);

    inst_i = ECALL; inst_addr_i = 32'h240;
    expect_cyc("re_acc", 1, 0, 0, 0, 0, 0);
    inst_i = NOP;
    expect_cyc("re_mepc",    1, 1, 32'h341, 32'h240, 0, 0);
    expect_cyc("re_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    expect_cyc("re_mcause",  1, 1, 32'h342, 32'hB, 0, 0);
    expect_cyc("re_assert",  1, 0, 0, 0, 1, 32'h200);
    expect_cyc("re_done",    0, 0, 0, 0, 0, 0);

    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL model_drain: %0d actions still pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
